fetch_stage: RTL and testbench

Instruction-fetch stage between the `PC` register and the IF/ID boundary of the five-stage RISC-V core. It issues word fetches to instruction memory over a request/grant/response handshake and computes the next PC and the PC write-enable. Fetched {pc, instr} pairs are buffered in a small queue and presented to decode with valid/ready. Branch/jump redirects flush the queue and discard any in-flight response.

---
 rtl/core_pkg.sv | 18 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and fetch-stage types
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched {pc, instr} entries with flush
module fetch_queue
  import core_pkg::*;
#(
  parameter int  FQ_DEPTH = 2,
  localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1,
  localparam int CW = $clog2(FQ_DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [FQ_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(FQ_DEPTH));
  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  // Empty queue presents zeros so decode never sees stale contents.
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Entry storage; no reset needed since head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage; FETCH_BYPASS_EN adds same-cycle response bypass
module fetch_stage
  import core_pkg::*;
#(
  parameter int FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_t  state;
  fetch_state_t  state_n;
  logic [XLEN-1:0] tag;
  logic          grant;
  logic          accept;
  logic          q_push;
  logic          q_pop;
  logic          q_flush;
  logic          q_valid;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  resp_entry;

  assign imem_addr  = pc_cur & ALIGN_MASK;
  assign resp_entry = '{pc: tag, instr: imem_rdata};

  // Next state, request and PC update; reset beats redirect beats normal fetch.
  always_comb begin
    state_n  = state;
    pc_en    = 1'b0;
    pc_next  = pc_cur;
    imem_req = 1'b0;
    grant    = 1'b0;
    accept   = 1'b0;
    q_flush  = 1'b0;
    if (reset) begin
      pc_en   = 1'b1;
      pc_next = RESET_PC;
      state_n = IDLE;
      q_flush = 1'b1;
    end else if (redirect) begin
      pc_en   = 1'b1;
      pc_next = redirect_pc & ALIGN_MASK;
      q_flush = 1'b1;
      // An outstanding response must still be swallowed unless it lands right now.
      if (state != IDLE) state_n = imem_rvalid ? IDLE : DROP;
    end else begin
      case (state)
        IDLE: begin
          imem_req = (q_count < CW'(FQ_DEPTH));
          if (imem_req && imem_gnt) begin
            grant   = 1'b1;
            pc_en   = 1'b1;
            pc_next = pc_cur + XLEN'(4);
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            accept  = 1'b1;
            state_n = IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register and PC tag of the single outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tag   <= '0;
    end else begin
      state <= state_n;
      if (grant) tag <= pc_cur;
    end
  end

  assign q_pop = q_valid && id_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  // Empty queue: hand the response straight to decode, queue it only if decode stalls.
  assign bypass   = accept && !q_valid;
  assign q_push   = accept && !(bypass && id_ready);
  assign id_valid = q_valid || bypass;
  assign id_instr = bypass ? imem_rdata : q_head.instr;
  assign id_pc    = bypass ? tag : q_head.pc;
`else
  assign q_push   = accept;
  assign id_valid = q_valid;
  assign id_instr = q_head.instr;
  assign id_pc    = q_head.pc;
`endif

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (q_flush),
    .push      (q_push),
    .push_data (resp_entry),
    .pop       (q_pop),
    .head      (q_head),
    .valid     (q_valid),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam int FQ_DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic        id_ready_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] rdata_i = '0;
  logic [31:0] pc_reg = '0;

  logic [31:0] pc_next;
  logic [31:0] imem_addr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        pc_en;
  logic        imem_req;
  logic        id_valid;

  always #5 clk = ~clk;

  fetch_stage #(.FQ_DEPTH(FQ_DEPTH)) dut (
    .clk         (clk),
    .reset       (reset_i),
    .pc_cur      (pc_reg),
    .pc_next     (pc_next),
    .pc_en       (pc_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (gnt_i),
    .imem_rvalid (rvalid_i),
    .imem_rdata  (rdata_i),
    .redirect    (redirect_i),
    .redirect_pc (redirect_pc_i),
    .id_valid    (id_valid),
    .id_ready    (id_ready_i),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  // PC register of the core
  always @(posedge clk) if (pc_en) pc_reg <= pc_next;

  int checks = 0;
  int failures = 0;
  int delivered = 0;
  logic [63:0] exp_q[$];

  int gnt_pct = 100, max_delay = 0, ready_pct = 100, redir_pct = 0, rst_pm = 0;
  bit force_reset = 1'b0, force_redirect = 1'b0;
  logic [31:0] force_target = '0;

  bit mem_pending = 1'b0;
  int mem_wait = 0;
  logic [31:0] mem_addr = '0;
  bit dut_out = 1'b0;
  logic [31:0] stream_pc = '0;
  bit was_reset = 1'b0, was_redirect = 1'b0;
  bit lat_arm = 1'b0, lat_next = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0000_0013 ^ {pc[26:0], 5'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit fire;
    logic [31:0] tgt;
    @(negedge clk);
    reset_i       = force_reset || ($urandom_range(999) < rst_pm);
    redirect_i    = force_redirect || ($urandom_range(99) < redir_pct);
    redirect_pc_i = force_redirect ? force_target : $urandom;
    rvalid_i      = mem_pending && (mem_wait == 0);
    rdata_i       = rvalid_i ? instr_of(mem_addr) : $urandom;
    gnt_i         = !mem_pending && ($urandom_range(99) < gnt_pct);
    id_ready_i    = ($urandom_range(99) < ready_pct);
    #1;
    tgt = redirect_pc_i & ~32'h3;
    if (reset_i) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_pc_en", pc_en, 1);
      chk("rst_pc_next", pc_next, 0);
    end else if (redirect_i) begin
      chk("redir_imem_req", imem_req, 0);
      chk("redir_pc_en", pc_en, 1);
      chk("redir_pc_next", pc_next, tgt);
    end else if (imem_req && gnt_i) begin
      chk("grant_addr", imem_addr, stream_pc);
      chk("grant_pc_en", pc_en, 1);
      chk("grant_pc_next", pc_next, stream_pc + 32'd4);
    end else begin
      chk("hold_pc_en", pc_en, 0);
      chk("hold_pc_next", pc_next, pc_reg);
    end
    if (dut_out && !reset_i) chk("one_outstanding", imem_req, 0);
    if (was_reset || was_redirect) chk("flush_id_valid", id_valid, 0);
    if (was_reset) begin
      chk("rst_id_pc", id_pc, 0);
      chk("rst_id_instr", id_instr, 0);
    end
    if (lat_next) begin
      chk("latency_next_cycle", id_valid, 32'(!BYP));
      lat_next = 1'b0;
    end
    if (lat_arm && rvalid_i && !reset_i && !redirect_i) begin
      chk("latency_same_cycle", id_valid, 32'(BYP));
      lat_arm  = 1'b0;
      lat_next = 1'b1;
    end
    fire = imem_req && gnt_i;
    #2;
    if (reset_i) begin
      exp_q.delete();
      stream_pc = '0;
      dut_out   = 1'b0;
    end else if (redirect_i) begin
      exp_q.delete();
      stream_pc = tgt;
      if (rvalid_i) dut_out = 1'b0;
    end else begin
      if (rvalid_i) dut_out = 1'b0;
      if (fire) begin
        exp_q.push_back({stream_pc, instr_of(stream_pc)});
        stream_pc = stream_pc + 32'd4;
        dut_out   = 1'b1;
      end
    end
    if (rvalid_i) mem_pending = 1'b0;
    else if (mem_pending) mem_wait--;
    if (fire) begin
      mem_pending = 1'b1;
      mem_addr    = imem_addr;
      mem_wait    = $urandom_range(max_delay);
    end
    was_reset    = reset_i;
    was_redirect = redirect_i;
  endtask

  // Monitor: every decode handshake must match the next expected fetch
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (!reset_i && id_valid && id_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery: id_pc=0x%08h with nothing expected (t=%0t)", id_pc, $time);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e[63:32]);
        chk("id_instr", id_instr, e[31:0]);
      end
      delivered++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    logic [31:0] p;

    force_reset = 1'b1;
    repeat (3) cycle();
    force_reset = 1'b0;

    // back-to-back fetch with 1-cycle memory
    lat_arm = 1'b1;
    d0 = delivered;
    repeat (20) cycle();
    chk("throughput_ge8", 32'(delivered - d0 >= 8), 1);

    // decode stall fills the queue and stops fetching
    ready_pct = 0;
    repeat (10) cycle();
    chk("full_imem_req", imem_req, 0);
    chk("full_id_valid", id_valid, 1);
    p = pc_reg;
    repeat (3) cycle();
    chk("full_pc_stable", pc_reg, p);
    ready_pct = 100;
    repeat (10) cycle();

    // redirect while a response is pending
    max_delay = 3;
    n = 0;
    while (!dut_out && n < 50) begin cycle(); n++; end
    chk("setup_wait", 32'(dut_out), 1);
    force_target = 32'h100; force_redirect = 1'b1;
    cycle();
    force_redirect = 1'b0;
    repeat (20) cycle();

    // redirect with grant offered, then redirect on the response cycle
    max_delay = 0;
    n = 0;
    while ((dut_out || mem_pending) && n < 50) begin cycle(); n++; end
    force_target = 32'h200; force_redirect = 1'b1;
    cycle();
    force_redirect = 1'b0;
    n = 0;
    while (!dut_out && n < 50) begin cycle(); n++; end
    chk("setup_grant", 32'(dut_out), 1);
    force_target = 32'h300; force_redirect = 1'b1;
    cycle();
    force_redirect = 1'b0;
    cycle();
    chk("idle_after_redirect", imem_req, 1);
    repeat (20) cycle();

    // reset while waiting with a queued entry
    ready_pct = 0; max_delay = 3;
    n = 0;
    while (!(dut_out && id_valid) && n < 50) begin cycle(); n++; end
    chk("setup_rst_wait", 32'(dut_out && id_valid), 1);
    force_reset = 1'b1;
    cycle();
    force_reset = 1'b0;
    ready_pct = 100;
    repeat (20) cycle();

    // randomized traffic
    gnt_pct = 70; max_delay = 3; ready_pct = 70; redir_pct = 4; rst_pm = 5;
    d0 = delivered;
    repeat (3000) cycle();
    chk("liveness", 32'(delivered - d0 > 200), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
